// File: rtl/pcint_pkg.sv
// Shared types and constants for the pin-change interrupt dispatch path.
package pcint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } pcint_state_t;

    localparam int N_PCINT        = 3;
    localparam int PCINT_VEC_BASE = 3;

endpackage

// File: rtl/pcint_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational.
module pcint_prio_enc #(
    parameter int N_SRC = 3,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the top down so the lowest set index is the last to win.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcint_irq_dispatch.sv
// Latches pin-change flags into PCIFR and dispatches one fixed-priority
// interrupt at a time to the core through an ack/done handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; waits for gie && any pending flag
// ST_REQ     | irq asserted with frozen sel/vector; waits for ack
// ST_SERVICE | core is in the handler; no new request until irq_done
module pcint_irq_dispatch
    import pcint_pkg::*;
#(
    parameter int N_SRC    = N_PCINT,
    parameter int VEC_W    = 8,
    parameter int VEC_BASE = PCINT_VEC_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] pcif,
    input  logic             gie,
    input  logic             clr_we,
    input  logic [N_SRC-1:0] clr_data,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic [N_SRC-1:0] pcifr,
    output logic             busy
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

    if (VEC_BASE + N_SRC - 1 >= (1 << VEC_W)) begin : g_vec_range_chk
        $error("pcint_irq_dispatch: highest vector does not fit in VEC_W bits");
    end

    pcint_state_t     r_state;
    logic [IDX_W-1:0] r_sel;
    logic [N_SRC-1:0] r_pending;
    logic             r_irq;
    logic             r_busy;
    logic [VEC_W-1:0] r_vec;

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_ack_take;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_w1c_clr;
    logic [N_SRC-1:0] w_pending_nxt;

    pcint_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req   (r_pending),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_ack_take = (r_state == ST_REQ) && irq_ack;
    assign w_ack_clr  = w_ack_take ? (ONE_HOT0 << r_sel) : '0;
    assign w_w1c_clr  = clr_we ? clr_data : '0;

    // A new event always wins over a same-cycle clear so it is never lost.
    assign w_pending_nxt = pcif | (r_pending & ~(w_w1c_clr | w_ack_clr));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_vec   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (gie && w_any) begin
                        r_state <= ST_REQ;
                        r_sel   <= w_idx;
                        r_vec   <= VEC_W'(VEC_BASE) + VEC_W'(w_idx);
                        r_irq   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over any withdraw condition.
                    if (irq_ack) begin
                        r_state <= ST_SERVICE;
                        r_irq   <= 1'b0;
                    end else if (!gie || !r_pending[r_sel]) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign irq     = r_irq;
    assign irq_vec = r_vec;
    assign pcifr   = r_pending;
    assign busy    = r_busy;

endmodule

// File: tb/tb_pcint_irq_dispatch.sv
// Directed bench for pcint_irq_dispatch with a cycle-level reference model.
module tb_pcint_irq_dispatch;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] pcif;
    logic       gie;
    logic       clr_we;
    logic [2:0] clr_data;
    logic       irq;
    logic [7:0] irq_vec;
    logic       irq_ack;
    logic       irq_done;
    logic [2:0] pcifr;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    pcint_irq_dispatch dut (
        .clk      (clk),
        .reset    (reset),
        .pcif     (pcif),
        .gie      (gie),
        .clr_we   (clr_we),
        .clr_data (clr_data),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .irq_done (irq_done),
        .pcifr    (pcifr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Model: pending flag set, the source currently being requested (-1 if
    // none) and whether the core is inside a handler.
    bit [2:0] m_pend;
    int       m_req;
    bit       m_svc;

    always @(posedge clk) begin
        bit [2:0] clr;
        bit [2:0] nxt;
        if (reset) begin
            m_pend = '0;
            m_req  = -1;
            m_svc  = 1'b0;
        end else begin
            clr = clr_we ? clr_data : 3'b000;
            if (m_req >= 0 && irq_ack) clr[m_req] = 1'b1;
            nxt = pcif | (m_pend & ~clr);
            if (m_req >= 0) begin
                if (irq_ack) begin
                    m_req = -1;
                    m_svc = 1'b1;
                end else if (!gie || !m_pend[m_req]) begin
                    m_req = -1;
                end
            end else if (m_svc) begin
                if (irq_done) m_svc = 1'b0;
            end else if (gie && m_pend != 3'b000) begin
                for (int i = 2; i >= 0; i--) if (m_pend[i]) m_req = i;
            end
            m_pend = nxt;
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_irq",   {7'd0, irq},   {7'd0, (m_req >= 0)});
            check("model_busy",  {7'd0, busy},  {7'd0, (m_req >= 0) || m_svc});
            check("model_pcifr", {5'd0, pcifr}, {5'd0, m_pend});
            if (m_req >= 0) check("model_vec", irq_vec, 8'(3 + m_req));
        end
    end

    task automatic cyc(input logic [2:0] p, input logic a, input logic d,
                       input logic cw, input logic [2:0] cd);
        pcif     = p;
        irq_ack  = a;
        irq_done = d;
        clr_we   = cw;
        clr_data = cd;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; gie = 1'b0; pcif = '0; clr_we = 1'b0; clr_data = '0;
        irq_ack = 1'b0; irq_done = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_irq",   {7'd0, irq},   8'd0);
        check("rst_vec",   irq_vec,       8'd0);
        check("rst_pcifr", {5'd0, pcifr}, 8'd0);
        check("rst_busy",  {7'd0, busy},  8'd0);
        reset = 1'b0;
        gie   = 1'b1;

        // single event
        cyc(3'b010, 0, 0, 0, 3'b000);
        check("single_pcifr", {5'd0, pcifr}, 8'b010);
        check("single_noirq", {7'd0, irq}, 8'd0);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("single_irq", {7'd0, irq}, 8'd1);
        check("single_vec", irq_vec, 8'd4);
        cyc(3'b000, 1, 0, 0, 3'b000);
        check("single_ack_irq",   {7'd0, irq},   8'd0);
        check("single_ack_pcifr", {5'd0, pcifr}, 8'd0);
        check("single_ack_busy",  {7'd0, busy},  8'd1);
        cyc(3'b000, 0, 1, 0, 3'b000);
        check("single_done_busy", {7'd0, busy}, 8'd0);

        // priority
        cyc(3'b110, 0, 0, 0, 3'b000);
        check("prio_pcifr0", {5'd0, pcifr}, 8'b110);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("prio_vec1", irq_vec, 8'd4);
        cyc(3'b000, 1, 0, 0, 3'b000);
        check("prio_pcifr1", {5'd0, pcifr}, 8'b100);
        cyc(3'b000, 0, 1, 0, 3'b000);
        check("prio_gap_irq", {7'd0, irq}, 8'd0);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("prio_irq2", {7'd0, irq}, 8'd1);
        check("prio_vec2", irq_vec, 8'd5);
        cyc(3'b000, 1, 0, 0, 3'b000);
        check("prio_pcifr2", {5'd0, pcifr}, 8'b000);
        cyc(3'b000, 0, 1, 0, 3'b000);

        // withdraw by W1C
        cyc(3'b001, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("w1c_vec", irq_vec, 8'd3);
        cyc(3'b000, 0, 0, 1, 3'b001);
        check("w1c_pcifr", {5'd0, pcifr}, 8'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("w1c_irq",  {7'd0, irq},  8'd0);
        check("w1c_busy", {7'd0, busy}, 8'd0);

        // withdraw by gie drop; pending survives
        cyc(3'b100, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("gie_vec", irq_vec, 8'd5);
        gie = 1'b0;
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("gie_irq",   {7'd0, irq},   8'd0);
        check("gie_pcifr", {5'd0, pcifr}, 8'b100);
        gie = 1'b1;
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("gie_reirq", {7'd0, irq}, 8'd1);
        cyc(3'b000, 1, 0, 0, 3'b000);
        cyc(3'b000, 0, 1, 0, 3'b000);

        // set beats ack-clear
        cyc(3'b001, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        cyc(3'b001, 1, 0, 0, 3'b000);
        check("coll_ack_pcifr", {5'd0, pcifr}, 8'b001);
        check("coll_ack_irq",   {7'd0, irq},   8'd0);
        cyc(3'b000, 0, 1, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("coll_ack_rereq", irq_vec, 8'd3);
        check("coll_ack_reirq", {7'd0, irq}, 8'd1);
        cyc(3'b000, 1, 0, 0, 3'b000);
        cyc(3'b000, 0, 1, 0, 3'b000);

        // set beats W1C
        cyc(3'b100, 0, 0, 1, 3'b100);
        check("coll_w1c_pcifr", {5'd0, pcifr}, 8'b100);
        cyc(3'b000, 0, 0, 0, 3'b000);
        cyc(3'b000, 1, 0, 0, 3'b000);
        cyc(3'b000, 0, 1, 0, 3'b000);

        // gating and no nesting
        gie = 1'b0;
        cyc(3'b111, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("gate_pcifr", {5'd0, pcifr}, 8'b111);
        check("gate_irq",   {7'd0, irq},   8'd0);
        gie = 1'b1;
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("gate_vec", irq_vec, 8'd3);
        cyc(3'b000, 1, 0, 0, 3'b000);
        check("svc_pcifr0", {5'd0, pcifr}, 8'b110);
        cyc(3'b001, 0, 0, 0, 3'b000);
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("svc_pcifr1", {5'd0, pcifr}, 8'b111);
        check("svc_noirq",  {7'd0, irq},   8'd0);
        check("svc_busy",   {7'd0, busy},  8'd1);

        // reset mid-service, then stray handshakes
        cyc(3'b000, 0, 0, 1, 3'b010);
        check("pre_rst_pcifr", {5'd0, pcifr}, 8'b101);
        reset = 1'b1;
        cyc(3'b000, 0, 0, 0, 3'b000);
        check("mid_rst_pcifr", {5'd0, pcifr}, 8'd0);
        check("mid_rst_busy",  {7'd0, busy},  8'd0);
        check("mid_rst_irq",   {7'd0, irq},   8'd0);
        check("mid_rst_vec",   irq_vec,       8'd0);
        reset = 1'b0;
        cyc(3'b000, 0, 1, 0, 3'b000);
        cyc(3'b000, 1, 0, 0, 3'b000);
        check("stray_busy", {7'd0, busy}, 8'd0);
        check("stray_irq",  {7'd0, irq},  8'd0);
        cyc(3'b000, 0, 0, 0, 3'b000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
